hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It reads the register-use demands (Tuse) of the instruction in D and the register-write promises (Tnew, write address, write enable) already held in the E and M pipeline registers. From these it drives `stall_D`, which freezes PC and the D register, and `CLR_E`, which loads a bubble into the E register. It also contains the multiply/divide busy tracker that holds back HI/LO instructions while the MDU is running.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/md_busy_tracker.sv | 45 ++++
 rtl/hazard_ctrl.sv | 72 +++++++
 tb/tb_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the hazard controller.
package cpu_pkg;

  // Tuse/Tnew field width
  localparam int T_W  = 3;
  // Register address width
  localparam int RA_W = 5;

  typedef logic [T_W-1:0]  t_val_t;
  typedef logic [RA_W-1:0] reg_addr_t;

  // Tuse encoding meaning "this source is not read"
  localparam t_val_t TUSE_NONE = 3'd7;

  // Write promise held in one pipeline register
  typedef struct packed {
    logic      rfwe;
    reg_addr_t waddr;
    t_val_t    tnew;
  } wr_promise_t;

  // One source against one producer: the producer writes the same nonzero
  // register and its result is ready later than the consumer needs it.
  // A Tnew of 0 can never exceed a Tuse, so forwarding cases fall out here.
  function automatic logic src_hazard(input reg_addr_t   src,
                                      input t_val_t      tuse,
                                      input wr_promise_t wp);
    return wp.rfwe && (wp.waddr != '0) && (wp.waddr == src) &&
           (tuse != TUSE_NONE) && (tuse < wp.tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and hazard_ctrl (slave).
// Optional macro HZ_PERF_EN adds the stall_cnt performance counter.
// There is no valid/ready handshake: every field is a level sampled each
// cycle, and the stall outputs answer combinationally in the same cycle.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  reg_addr_t rs_D;
  reg_addr_t rt_D;
  t_val_t    tuse_rs_D;
  t_val_t    tuse_rt_D;
  logic      rfwe_E;
  reg_addr_t writeaddr_E;
  t_val_t    tnew_E;
  logic      rfwe_M;
  reg_addr_t writeaddr_M;
  t_val_t    tnew_M;
  logic      md_D;
  logic      md_start_E;
  logic      md_div_E;
  logic      stall_D;
  logic      CLR_E;
  logic      md_busy;
`ifdef HZ_PERF_EN
  logic [31:0] stall_cnt;
`endif

`ifdef HZ_PERF_EN
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    output rfwe_E, writeaddr_E, tnew_E, rfwe_M, writeaddr_M, tnew_M,
    output md_D, md_start_E, md_div_E,
    input  stall_D, CLR_E, md_busy, stall_cnt
  );
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    input  rfwe_E, writeaddr_E, tnew_E, rfwe_M, writeaddr_M, tnew_M,
    input  md_D, md_start_E, md_div_E,
    output stall_D, CLR_E, md_busy, stall_cnt
  );
`else
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    output rfwe_E, writeaddr_E, tnew_E, rfwe_M, writeaddr_M, tnew_M,
    output md_D, md_start_E, md_div_E,
    input  stall_D, CLR_E, md_busy
  );
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    input  rfwe_E, writeaddr_E, tnew_E, rfwe_M, writeaddr_M, tnew_M,
    input  md_D, md_start_E, md_div_E,
    output stall_D, CLR_E, md_busy
  );
`endif

endinterface

// File: rtl/md_busy_tracker.sv
// Multiply/divide busy tracker: counts down the remaining MDU cycles after
// a mult/div leaves E. md_busy_o also covers the start cycle itself.
module md_busy_tracker #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_div_i,
  output logic md_busy_o
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;

  // Load on an accepted start, otherwise count down and saturate at zero.
  // A start while still counting is ignored; the stall logic keeps it from
  // happening.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end else if (md_start_i) begin
      md_cnt_d = md_div_i ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    end
  end

  // Counter register, cleared asynchronously so reset aborts a running op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  assign md_busy_o = (md_cnt_q != '0) | md_start_i;

  // A second mult/div must never reach E while the MDU is still running
  a_no_overlap_start: assert property (
    @(posedge clk) disable iff (reset) !(md_start_i && (md_cnt_q != '0))
  );

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: compares D-stage Tuse against E/M Tnew
// promises and the MDU busy state, and freezes D / bubbles E on a hazard.
// Optional macro HZ_PERF_EN adds a 32-bit stalled-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  wr_promise_t wp_e;
  wr_promise_t wp_m;
  logic        reg_hz;
  logic        md_hz;
  logic        md_busy;
  logic        stall;

  assign wp_e = '{rfwe: hz.rfwe_E, waddr: hz.writeaddr_E, tnew: hz.tnew_E};
  assign wp_m = '{rfwe: hz.rfwe_M, waddr: hz.writeaddr_M, tnew: hz.tnew_M};

  // Register hazard: either source of D against either producer in E or M
  always_comb begin
    reg_hz = 1'b0;
    if (src_hazard(hz.rs_D, hz.tuse_rs_D, wp_e)) reg_hz = 1'b1;
    if (src_hazard(hz.rs_D, hz.tuse_rs_D, wp_m)) reg_hz = 1'b1;
    if (src_hazard(hz.rt_D, hz.tuse_rt_D, wp_e)) reg_hz = 1'b1;
    if (src_hazard(hz.rt_D, hz.tuse_rt_D, wp_m)) reg_hz = 1'b1;
  end

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .md_start_i (hz.md_start_E),
    .md_div_i   (hz.md_div_E),
    .md_busy_o  (md_busy)
  );

  assign md_hz = hz.md_D & md_busy;

  // Reset masks the stall directly so it drops without waiting for a clock
  assign stall      = (reg_hz | md_hz) & ~reset;
  assign hz.stall_D = stall;
  assign hz.CLR_E   = stall;
  assign hz.md_busy = md_busy;

`ifdef HZ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count every stalled cycle; natural 32-bit wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. Define HZ_PERF_EN to also cover the stall counter.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int W = 3;  // {stall_D, CLR_E, md_busy}

  logic clk;
  logic reset;

  hazard_ctrl_if hz_bus();

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
`ifdef HZ_PERF_EN
  logic [31:0]  cnt_exp_q[$];
  string        cnt_name_q[$];
`endif
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic idle();
    hz_bus.rs_D        = 5'd0;
    hz_bus.rt_D        = 5'd0;
    hz_bus.tuse_rs_D   = TUSE_NONE;
    hz_bus.tuse_rt_D   = TUSE_NONE;
    hz_bus.rfwe_E      = 1'b0;
    hz_bus.writeaddr_E = 5'd0;
    hz_bus.tnew_E      = 3'd0;
    hz_bus.rfwe_M      = 1'b0;
    hz_bus.writeaddr_M = 5'd0;
    hz_bus.tnew_M      = 3'd0;
    hz_bus.md_D        = 1'b0;
    hz_bus.md_start_E  = 1'b0;
    hz_bus.md_div_E    = 1'b0;
  endtask

  task automatic set_e(input logic [4:0] wa, input logic [2:0] tn);
    hz_bus.rfwe_E = 1'b1; hz_bus.writeaddr_E = wa; hz_bus.tnew_E = tn;
  endtask

  task automatic set_m(input logic [4:0] wa, input logic [2:0] tn);
    hz_bus.rfwe_M = 1'b1; hz_bus.writeaddr_M = wa; hz_bus.tnew_M = tn;
  endtask

  task automatic push(input string nm, input logic st, input logic busy);
    exp_q.push_back({st, st, busy});
    name_q.push_back(nm);
  endtask

`ifdef HZ_PERF_EN
  task automatic push_cnt(input string nm, input logic [31:0] c);
    cnt_exp_q.push_back(c);
    cnt_name_q.push_back(nm);
  endtask
`endif

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string        nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {hz_bus.stall_D, hz_bus.CLR_E, hz_bus.md_busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: stall/clr/busy got %b required %b", nm, got, e);
      end
    end
`ifdef HZ_PERF_EN
    if (cnt_exp_q.size() != 0) begin
      logic [31:0] ce;
      string       cn;
      ce = cnt_exp_q.pop_front();
      cn = cnt_name_q.pop_front();
      n_checks++;
      if (hz_bus.stall_cnt !== ce) begin
        n_fail++;
        $display("FAIL %s: stall_cnt got %0h required %0h", cn, hz_bus.stall_cnt, ce);
      end
    end
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    tick();

    // Reset state: hazard inputs present but reset masks the stall
    set_e(5'd1, 3'd2); hz_bus.rs_D = 5'd1; hz_bus.tuse_rs_D = 3'd1; hz_bus.md_D = 1'b1;
    push("reset_state", 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Load-use: one stall, then M has tnew 1 -> released
    idle(); set_e(5'd1, 3'd2); hz_bus.rs_D = 5'd1; hz_bus.tuse_rs_D = 3'd1;
    push("load_use_stall", 1'b1, 1'b0);
    tick();
    idle(); set_m(5'd1, 3'd1); hz_bus.rs_D = 5'd1; hz_bus.tuse_rs_D = 3'd1;
    push("load_use_release", 1'b0, 1'b0);
    tick();

    // Branch after ALU op
    idle(); set_e(5'd5, 3'd1); hz_bus.rs_D = 5'd5; hz_bus.tuse_rs_D = 3'd0;
    push("branch_alu_stall", 1'b1, 1'b0);
    tick();
    idle(); set_m(5'd5, 3'd0); hz_bus.rs_D = 5'd5; hz_bus.tuse_rs_D = 3'd0;
    push("branch_alu_release", 1'b0, 1'b0);
    tick();

    // rt against M producer still pending
    idle(); set_m(5'd7, 3'd1); hz_bus.rt_D = 5'd7; hz_bus.tuse_rt_D = 3'd0;
    push("rt_vs_m_stall", 1'b1, 1'b0);
    tick();

    // $zero destination never stalls
    idle(); set_e(5'd0, 3'd2); hz_bus.rs_D = 5'd0; hz_bus.tuse_rs_D = 3'd0;
    push("zero_reg", 1'b0, 1'b0);
    tick();

    // Unused rt source
    idle(); set_e(5'd3, 3'd2); hz_bus.rt_D = 5'd3; hz_bus.tuse_rt_D = TUSE_NONE;
    push("tuse_none", 1'b0, 1'b0);
    tick();

    // Write enable low
    idle(); set_e(5'd4, 3'd2); hz_bus.rfwe_E = 1'b0; hz_bus.rs_D = 5'd4; hz_bus.tuse_rs_D = 3'd0;
    push("rfwe_low", 1'b0, 1'b0);
    tick();

    // Tnew 0 left to forwarding
    idle(); set_e(5'd6, 3'd0); hz_bus.rs_D = 5'd6; hz_bus.tuse_rs_D = 3'd0;
    push("tnew_zero", 1'b0, 1'b0);
    tick();

    // Address mismatch
    idle(); set_e(5'd8, 3'd2); hz_bus.rs_D = 5'd9; hz_bus.tuse_rs_D = 3'd0;
    push("addr_mismatch", 1'b0, 1'b0);
    tick();

    // Tuse equal to Tnew: ready just in time
    idle(); set_e(5'd10, 3'd2); hz_bus.rt_D = 5'd10; hz_bus.tuse_rt_D = 3'd2;
    push("tuse_eq_tnew", 1'b0, 1'b0);
    tick();

    // Mult then mflo: stall t..t+4, free at t+5
    idle(); hz_bus.md_start_E = 1'b1; hz_bus.md_D = 1'b1;
    push("mult_t0", 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      idle(); hz_bus.md_D = 1'b1;
      push($sformatf("mult_t%0d", i), 1'b1, 1'b1);
      tick();
    end
    idle(); hz_bus.md_D = 1'b1;
    push("mult_t5_issue", 1'b0, 1'b0);
    tick();

    // Divide window: busy t..t+9, non-MDU D instruction unaffected
    idle(); hz_bus.md_start_E = 1'b1; hz_bus.md_div_E = 1'b1;
    push("div_t0", 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 9; i++) begin
      idle();
      push($sformatf("div_t%0d", i), 1'b0, 1'b1);
      tick();
    end
    idle(); hz_bus.md_D = 1'b1;
    push("div_t10_issue", 1'b0, 1'b0);
    tick();

    // Register hazard and MDU hazard together
    idle(); hz_bus.md_start_E = 1'b1; set_e(5'd2, 3'd1); hz_bus.md_D = 1'b1;
    hz_bus.rs_D = 5'd2; hz_bus.tuse_rs_D = 3'd0;
    push("reg_and_md", 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      idle();
      push($sformatf("drain_%0d", i), 1'b0, (i <= 4));
      tick();
    end

    // Reset mid-divide
    idle(); hz_bus.md_start_E = 1'b1; hz_bus.md_div_E = 1'b1; hz_bus.md_D = 1'b1;
    push("rdiv_t0", 1'b1, 1'b1);
    tick();
    idle(); hz_bus.md_D = 1'b1;
    push("rdiv_t1", 1'b1, 1'b1);
    tick();
    push("rdiv_t2", 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    push("rdiv_reset_now", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    push("rdiv_after_reset", 1'b0, 1'b0);
    tick();

`ifdef HZ_PERF_EN
    // Clear counter, then three separate load-use stalls
    reset = 1'b1; idle();
    push_cnt("perf_reset", 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(); set_e(5'd1, 3'd2); hz_bus.rs_D = 5'd1; hz_bus.tuse_rs_D = 3'd1;
      push($sformatf("perf_stall_%0d", i), 1'b1, 1'b0);
      tick();
      idle();
      tick();
    end
    push_cnt("perf_three", 32'd3);
    tick();
    // Preload near wrap
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    idle(); set_e(5'd1, 3'd2); hz_bus.rs_D = 5'd1; hz_bus.tuse_rs_D = 3'd1;
    push("perf_wrap_stall", 1'b1, 1'b0);
    tick();
    idle();
    push_cnt("perf_wrap", 32'd0);
    tick();
`endif

    // Drain the scoreboard with a bounded wait
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
